img_sram_stream_ctrl: RTL and testbench

- Master-side sequencer that drives the img_sram_ctrl_t control bundle of the 256x256x8 image SRAM.
- Two commands over a rectangular pixel region, both in raster order (col fastest, then row):
  - LOAD: writes an incoming pixel stream into the SRAM.
  - DUMP: streams SRAM contents out with valid/ready backpressure.
- Owns all SRAM timing rules, so that convolution and host-interface logic only ever see plain streams.

---
 rtl/img_sram_stream_ctrl.sv | 143 ++++++++++++++
 tb/tb_img_sram_stream_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/img_sram_stream_ctrl.sv
// rtl/img_sram_stream_ctrl.sv - region LOAD/DUMP sequencer for the 256x256x8 image SRAM
// Turns pixel streams into registered single-cycle SRAM WRITE/READ accesses in raster order.
package img_sram_pkg;
    typedef struct packed {
        logic [7:0] din;
        logic [7:0] row;
        logic [7:0] col;
        logic       write_en;
        logic       sense_en;
    } img_sram_ctrl_t;
endpackage

module img_sram_stream_ctrl
    import img_sram_pkg::*;
#(
    parameter int OUT_FIFO_DEPTH = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           cmd,
    input  logic [7:0]     row_lo,
    input  logic [7:0]     row_hi,
    input  logic [7:0]     col_lo,
    input  logic [7:0]     col_hi,
    input  logic [7:0]     s_data,
    input  logic           s_valid,
    output logic           s_ready,
    output logic [7:0]     m_data,
    output logic           m_valid,
    input  logic           m_ready,
    output img_sram_ctrl_t ctrl,
    input  logic [7:0]     sram_dout,
    output logic           busy,
    output logic           done,
    output logic           err
);
    localparam int AW = $clog2(OUT_FIFO_DEPTH);
    localparam int CW = $clog2(OUT_FIFO_DEPTH + 1);
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(OUT_FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DUMP, S_DRAIN, S_DONE} state_t;
    state_t state, state_nx;

    logic [7:0]    row_hi_q, col_lo_q, col_hi_q, cur_row, cur_col;
    logic          err_q, inflight;
    logic [7:0]    mem [OUT_FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [CW:0]   occ;
    logic          bad_region, last_pix, wr_fire, rd_fire, pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(OUT_FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign bad_region = (row_lo > row_hi) || (col_lo > col_hi);
    assign last_pix   = (cur_row == row_hi_q) && (cur_col == col_hi_q);
    assign pop        = m_valid & m_ready;
    // Credit counts buffered plus in-flight reads, net of the beat leaving this cycle.
    assign occ        = {1'b0, count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};
    assign wr_fire    = (state == S_LOAD) && s_valid;
    assign rd_fire    = (state == S_DUMP) && (occ < DEPTH_W);

    assign s_ready = (state == S_LOAD);
    assign busy    = (state != S_IDLE);
    assign done    = (state == S_DONE);
    assign err     = done & err_q;
    assign m_valid = (count != '0);
    assign m_data  = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = bad_region ? S_DONE : (cmd ? S_DUMP : S_LOAD);
            S_LOAD:  if (wr_fire && last_pix) state_nx = S_DONE;
            S_DUMP:  if (rd_fire && last_pix) state_nx = S_DRAIN;
            S_DRAIN: if (!inflight && count == '0) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_hi_q <= '0;
            col_lo_q <= '0;
            col_hi_q <= '0;
            cur_row  <= '0;
            cur_col  <= '0;
            err_q    <= 1'b0;
            ctrl     <= '{din: 8'h00, row: 8'h00, col: 8'h00, write_en: 1'b0, sense_en: 1'b1};
        end else begin
            ctrl.write_en <= 1'b0;
            ctrl.sense_en <= 1'b1;
            if (state == S_IDLE && start) begin
                cur_row  <= row_lo;
                cur_col  <= col_lo;
                row_hi_q <= row_hi;
                col_lo_q <= col_lo;
                col_hi_q <= col_hi;
                err_q    <= bad_region;
            end
            if (wr_fire || rd_fire) begin
                ctrl.row      <= cur_row;
                ctrl.col      <= cur_col;
                ctrl.write_en <= wr_fire;
                ctrl.sense_en <= wr_fire;
                if (cur_col == col_hi_q) begin
                    cur_col <= col_lo_q;
                    cur_row <= cur_row + 8'd1;
                end else begin
                    cur_col <= cur_col + 8'd1;
                end
            end
            if (wr_fire) ctrl.din <= s_data;
        end
    end

    // sram_dout is only valid on the edge right after a READ cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            for (int i = 0; i < OUT_FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            inflight <= rd_fire;
            if (inflight) begin
                mem[wr_ptr] <= sram_dout;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            count <= count + {{(CW-1){1'b0}}, inflight} - {{(CW-1){1'b0}}, pop};
        end
    end
endmodule

// File: tb/tb_img_sram_stream_ctrl.sv
// tb/tb_img_sram_stream_ctrl.sv - scoreboard bench for img_sram_stream_ctrl
module tb_img_sram_stream_ctrl;
    import img_sram_pkg::*;
    localparam int DEPTH = 2;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, cmd = 1'b0;
    logic [7:0] row_lo = 0, row_hi = 0, col_lo = 0, col_hi = 0, s_data = 0;
    logic s_valid = 1'b0, m_ready;
    logic s_ready, m_valid, busy, done, err;
    logic [7:0] m_data, sram_dout;
    img_sram_ctrl_t ctrl;

    logic [7:0]  sram_mem [65536];
    logic [7:0]  ref_mem  [65536];
    logic [23:0] wr_q [$];
    logic [15:0] rd_q [$];
    logic [7:0]  exp_q [$];

    int total = 0, bad = 0, cyc = 0, start_pe = 0;
    int mode = 0, pidx = 0, reads_issued = 0, beats_done = 0, cmd_beats = 0, last_beat_cyc = 0;
    int first_read_cyc = -1, first_valid_cyc = -1;
    logic prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;

    img_sram_stream_ctrl #(.OUT_FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cmd(cmd),
        .row_lo(row_lo), .row_hi(row_hi), .col_lo(col_lo), .col_hi(col_hi),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .ctrl(ctrl), .sram_dout(sram_dout),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) if (ctrl.write_en) sram_mem[{ctrl.row, ctrl.col}] <= ctrl.din;
    assign sram_dout = ctrl.sense_en ? 8'hA5 : sram_mem[{ctrl.row, ctrl.col}];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            m_ready = 1'b0;
            prev_stall = 1'b0;
            reads_issued = 0;
            beats_done = 0;
        end else begin
            pidx++;
            case (mode)
                0:       m_ready = 1'b1;
                1:       m_ready = (pidx % 3 == 0);
                2:       m_ready = 1'b0;
                default: m_ready = ($urandom_range(0, 1) == 1);
            endcase
            if (prev_stall) begin
                check_eq("hold_valid", m_valid, 1);
                check_eq("hold_data", m_data, prev_data);
            end
            if (ctrl.write_en) begin
                check_eq("wr_enc", ctrl.sense_en, 1);
                check_eq("wr_expected", wr_q.size() > 0, 1);
                if (wr_q.size() > 0) check_eq("wr_access", {ctrl.row, ctrl.col, ctrl.din}, wr_q.pop_front());
            end
            if (!ctrl.sense_en) begin
                reads_issued++;
                if (first_read_cyc < 0) first_read_cyc = cyc;
                check_eq("rd_expected", rd_q.size() > 0, 1);
                if (rd_q.size() > 0) check_eq("rd_addr", {ctrl.row, ctrl.col}, rd_q.pop_front());
                check_eq("rd_credit", (reads_issued - beats_done) <= DEPTH, 1);
            end
            if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (m_valid && m_ready) begin
                beats_done++;
                cmd_beats++;
                check_eq("beat_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) check_eq("m_data", m_data, exp_q.pop_front());
                if (mode == 0 && cmd_beats > 1) check_eq("throughput", cyc, last_beat_cyc + 1);
                last_beat_cyc = cyc;
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
        end
    end

    task automatic start_cmd(input logic c, input logic [7:0] rl, rh, cl, ch, input bit restart);
        cmd = c; row_lo = rl; row_hi = rh; col_lo = cl; col_hi = ch;
        start = 1'b1;
        start_pe = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        cmd = ~c;
        row_lo = 8'($urandom); row_hi = 8'($urandom); col_lo = 8'($urandom); col_hi = 8'($urandom);
        check_eq("busy_run", busy, 1);
        if (restart) begin
            @(negedge clk); start = 1'b1;
            @(negedge clk); start = 1'b0;
        end
    endtask

    task automatic wait_done(input int limit, input logic exp_err);
        for (int i = 0; i < limit && !done; i++) @(negedge clk);
        check_eq("done", done, 1);
        check_eq("err", err, exp_err);
        @(negedge clk);
        check_eq("done_pulse", done, 0);
        check_eq("idle", busy, 0);
    endtask

    task automatic do_load(input logic [7:0] rl, rh, cl, ch, input logic [7:0] base, input bit gaps);
        int idx = 0;
        logic [7:0] d;
        start_cmd(1'b0, rl, rh, cl, ch, 1'b0);
        for (int r = rl; r <= rh; r++) begin
            for (int c = cl; c <= ch; c++) begin
                if (gaps && $urandom_range(0, 2) == 0) begin
                    s_valid = 1'b0;
                    @(negedge clk);
                end
                d = base + idx[7:0];
                s_valid = 1'b1;
                s_data = d;
                ref_mem[{r[7:0], c[7:0]}] = d;
                wr_q.push_back({r[7:0], c[7:0], d});
                start = (idx == 1);
                check_eq("s_ready", s_ready, 1);
                @(negedge clk);
                idx++;
            end
        end
        s_valid = 1'b0;
        start = 1'b0;
        check_eq("load_last_wr", ctrl.write_en, 1);
        check_eq("load_last_done", done, 1);
        wait_done(20, 1'b0);
        check_eq("wr_q_empty", wr_q.size(), 0);
    endtask

    task automatic do_dump(input logic [7:0] rl, rh, cl, ch, input int m, input bit check_lat);
        int n = 0;
        for (int r = rl; r <= rh; r++) begin
            for (int c = cl; c <= ch; c++) begin
                rd_q.push_back({r[7:0], c[7:0]});
                exp_q.push_back(ref_mem[{r[7:0], c[7:0]}]);
                n++;
            end
        end
        mode = m;
        cmd_beats = 0;
        first_read_cyc = -1;
        first_valid_cyc = -1;
        start_cmd(1'b1, rl, rh, cl, ch, 1'b1);
        wait_done(4 * n + 50, 1'b0);
        check_eq("rd_q_empty", rd_q.size(), 0);
        check_eq("exp_q_empty", exp_q.size(), 0);
        check_eq("m_valid_idle", m_valid, 0);
        if (check_lat) begin
            check_eq("first_read_lat", first_read_cyc - start_pe, 1);
            check_eq("first_valid_lat", first_valid_cyc - start_pe, 2);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_eq("rst_we", ctrl.write_en, 0);
        check_eq("rst_se", ctrl.sense_en, 1);
        check_eq("rst_addr", {ctrl.row, ctrl.col, ctrl.din}, 0);
        check_eq("rst_outs", {s_ready, m_valid, busy, done, err}, 0);
        check_eq("rst_m_data", m_data, 0);
        rst_n = 1'b1;
        @(negedge clk);

        do_load(8'd10, 8'd11, 8'd5, 8'd7, 8'h01, 1'b0);
        do_dump(8'd10, 8'd11, 8'd5, 8'd7, 0, 1'b1);
        do_dump(8'd10, 8'd11, 8'd5, 8'd7, 1, 1'b0);

        do_load(8'd3, 8'd5, 8'd200, 8'd203, 8'h40, 1'b1);
        do_dump(8'd3, 8'd5, 8'd200, 8'd203, 3, 1'b0);

        start_cmd(1'b0, 8'd20, 8'd19, 8'd0, 8'd3, 1'b0);
        check_eq("err_we", ctrl.write_en, 0);
        check_eq("err_se", ctrl.sense_en, 1);
        wait_done(2, 1'b1);
        start_cmd(1'b1, 8'd0, 8'd1, 8'd9, 8'd8, 1'b0);
        check_eq("err2_se", ctrl.sense_en, 1);
        wait_done(2, 1'b1);

        do_load(8'd255, 8'd255, 8'd255, 8'd255, 8'hC3, 1'b0);
        do_dump(8'd255, 8'd255, 8'd255, 8'd255, 1, 1'b0);

        do_load(8'd254, 8'd255, 8'd0, 8'd255, 8'h10, 1'b0);
        do_dump(8'd254, 8'd255, 8'd0, 8'd255, 0, 1'b1);

        for (int r = 10; r <= 11; r++)
            for (int c = 5; c <= 7; c++) begin
                rd_q.push_back({r[7:0], c[7:0]});
                exp_q.push_back(ref_mem[{r[7:0], c[7:0]}]);
            end
        mode = 2;
        start_cmd(1'b1, 8'd10, 8'd11, 8'd5, 8'd7, 1'b0);
        for (int i = 0; i < 20 && !m_valid; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        check_eq("pre_rst_valid", m_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("abort_we", ctrl.write_en, 0);
        check_eq("abort_se", ctrl.sense_en, 1);
        check_eq("abort_outs", {s_ready, m_valid, busy, done, err}, 0);
        check_eq("abort_m_data", m_data, 0);
        rd_q.delete();
        exp_q.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        do_dump(8'd10, 8'd11, 8'd5, 8'd7, 0, 1'b1);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule
